// File: rtl/modchip_pkg.sv
// Shared types and constants for the modchip SPI receive path.
// Pure declarations: no latency, no backpressure.
package modchip_pkg;

    localparam int BYTE_W      = 8;
    localparam int BITCNT_W    = 3;
    localparam int BYTECNT_MAX = 255;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_t;

    typedef logic [BYTE_W-1:0]   byte_t;
    typedef logic [BITCNT_W-1:0] bitcnt_t;

    // Shift one serial bit into the partial byte in the selected bit order.
    function automatic byte_t shift_in(input byte_t cur, input logic bit_in, input bit msb_first);
        byte_t nxt;
        if (msb_first) begin
            nxt = {cur[BYTE_W-2:0], bit_in};
        end else begin
            nxt = {bit_in, cur[BYTE_W-1:1]};
        end
        return nxt;
    endfunction

endpackage

// File: rtl/modchip_spi_rx_if.sv
// SPI pin bundle plus the parallel byte bus handed to the key-check stage.
// master = receiver side, slave = pin driver / byte consumer side.
interface modchip_spi_rx_if;
    import modchip_pkg::*;

    logic         spi_sclk;
    logic         spi_cs_n;
    logic         spi_mosi;
    byte_t        uprocessor_din;
    logic         uprocessor_wren;
    logic         frame_err;
    logic         busy;
    logic [7:0]   byte_cnt;

    modport master (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output uprocessor_din,
        output uprocessor_wren,
        output frame_err,
        output busy,
        output byte_cnt
    );

    modport slave (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  uprocessor_din,
        input  uprocessor_wren,
        input  frame_err,
        input  busy,
        input  byte_cnt
    );

endinterface

// File: rtl/modchip_sync.sv
// Multi-flop synchroniser for one asynchronous bit; latency DEPTH clk cycles.
// No backpressure: samples every cycle, resets to RST_VAL.
module modchip_sync #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] stg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg <= {DEPTH{RST_VAL}};
        end else begin
            stg <= {stg[DEPTH-2:0], d};
        end
    end

    assign q = stg[DEPTH-1];

endmodule

// File: rtl/modchip_spi_rx.sv
// SPI mode-0 byte receiver; 8th raw sclk rise to wren is SYNC_STAGES+2 clk.
// No backpressure: every completed byte is presented for exactly one cycle.
module modchip_spi_rx
    import modchip_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    modchip_spi_rx_if.master        bus
);

    logic       sclk_s;
    logic       cs_n_s;
    logic       mosi_s;
    logic       sclk_d;
    logic       valid_edge;

    rx_state_t  state_q;
    rx_state_t  state_nxt;
    logic       busy_c;
    logic       frame_end;

    byte_t      shreg_q;
    bitcnt_t    bitcnt_q;
    logic       byte_done_q;

    byte_t      din_q;
    logic       wren_q;
    logic       frame_err_q;
    logic [7:0] byte_cnt_q;

    modchip_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (bus.spi_sclk),
        .q   (sclk_s)
    );

    modchip_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk (clk),
        .rst (rst),
        .d   (bus.spi_cs_n),
        .q   (cs_n_s)
    );

    modchip_sync #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (bus.spi_mosi),
        .q   (mosi_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    // A deasserted select always beats a coincident sclk rise.
    assign valid_edge = sclk_s & ~sclk_d & ~cs_n_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (!cs_n_s) state_nxt = RECV;
            RECV:    if (cs_n_s)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_c    = 1'b0;
        frame_end = 1'b0;
        if (state_q == RECV) begin
            busy_c    = 1'b1;
            frame_end = cs_n_s;
        end
    end

    // Byte assembly; the completed byte is held in shreg_q for one cycle
    // while byte_done_q is up, then copied to the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (frame_end) begin
                shreg_q  <= '0;
                bitcnt_q <= '0;
            end else if (valid_edge) begin
                shreg_q     <= shift_in(shreg_q, mosi_s, MSB_FIRST);
                bitcnt_q    <= bitcnt_q + 1'b1;
                byte_done_q <= (bitcnt_q == '1);
            end
        end
    end

    // frame_err and wren are exclusive by construction: a partial byte at
    // frame end implies the counter did not just wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q       <= '0;
            wren_q      <= 1'b0;
            frame_err_q <= 1'b0;
            byte_cnt_q  <= '0;
        end else begin
            wren_q      <= byte_done_q;
            frame_err_q <= frame_end && (bitcnt_q != '0);
            if (byte_done_q) begin
                din_q <= shreg_q;
                if (byte_cnt_q != 8'(BYTECNT_MAX)) begin
                    byte_cnt_q <= byte_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.uprocessor_din  = din_q;
    assign bus.uprocessor_wren = wren_q;
    assign bus.frame_err       = frame_err_q;
    assign bus.busy            = busy_c;
    assign bus.byte_cnt        = byte_cnt_q;

endmodule

// File: tb/tb_modchip_spi_rx.sv
// Drives MSB-first and LSB-first receivers from one SPI stimulus and checks
// delivered bytes, counts, frame errors and latency against a byte-level model.
module tb_modchip_spi_rx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;

    always #5 clk = ~clk;

    modchip_spi_rx_if bus_m ();
    modchip_spi_rx_if bus_l ();

    assign bus_m.spi_sclk = sclk;
    assign bus_m.spi_cs_n = cs_n;
    assign bus_m.spi_mosi = mosi;
    assign bus_l.spi_sclk = sclk;
    assign bus_l.spi_cs_n = cs_n;
    assign bus_l.spi_mosi = mosi;

    modchip_spi_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    modchip_spi_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed events, written only by the monitor.
    logic [7:0] got_m[$];
    logic [7:0] got_l[$];
    int err_m   = 0;
    int err_l   = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (bus_m.uprocessor_wren === 1'b1) got_m.push_back(bus_m.uprocessor_din);
        if (bus_l.uprocessor_wren === 1'b1) got_l.push_back(bus_l.uprocessor_din);
        if (bus_m.frame_err === 1'b1) err_m++;
        if (bus_l.frame_err === 1'b1) err_l++;
        if ((bus_m.uprocessor_wren === 1'b1 && bus_m.frame_err === 1'b1) ||
            (bus_l.uprocessor_wren === 1'b1 && bus_l.frame_err === 1'b1)) overlap++;
    end

    // Reference model state.
    logic [7:0] tx_q[$];
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    int         rd_idx    = 0;
    int         err_exp   = 0;
    int         model_cnt = 0;
    logic [7:0] last_m    = 8'h00;
    logic [7:0] last_l    = 8'h00;
    int         lat       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit measure);
        mosi = b;
        tick($urandom_range(2, 4));
        sclk = 1'b1;
        if (measure) begin
            lat = 0;
            for (int k = 1; k <= 12; k++) begin
                tick(1);
                if (bus_l.uprocessor_wren === 1'b1) begin
                    lat = k;
                    break;
                end
            end
        end else begin
            tick($urandom_range(2, 4));
        end
        sclk = 1'b0;
    endtask

    task automatic send_frame(input int n_extra, input bit measure_first);
        logic [7:0] cur;
        logic [7:0] rev;
        cs_n = 1'b0;
        tick(4);
        chk("busy_in_frame", {31'd0, bus_m.busy}, 32'd1);
        for (int k = 0; k < tx_q.size(); k++) begin
            cur = tx_q[k];
            for (int i = 7; i >= 0; i--) send_bit(cur[i], measure_first && (k == 0) && (i == 0));
            // LSB-first receiver: the j-th bit on the wire lands in bit j.
            for (int j = 0; j < 8; j++) rev[j] = cur[7-j];
            exp_m.push_back(cur);
            exp_l.push_back(rev);
            last_m = cur;
            last_l = rev;
            if (model_cnt < 255) model_cnt++;
        end
        for (int i = 0; i < n_extra; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        if (n_extra > 0) err_exp++;
        tick(3);
        cs_n = 1'b1;
        tick(10);
        tx_q.delete();
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "/nbytes_m"}, got_m.size(), exp_m.size());
        chk({tag, "/nbytes_l"}, got_l.size(), exp_l.size());
        for (int i = rd_idx; i < exp_m.size(); i++) begin
            if (i < got_m.size()) chk($sformatf("%s/byte_m[%0d]", tag, i), got_m[i], exp_m[i]);
            if (i < got_l.size()) chk($sformatf("%s/byte_l[%0d]", tag, i), got_l[i], exp_l[i]);
        end
        rd_idx = exp_m.size();
        chk({tag, "/din_m"}, bus_m.uprocessor_din, last_m);
        chk({tag, "/din_l"}, bus_l.uprocessor_din, last_l);
        chk({tag, "/byte_cnt_m"}, bus_m.byte_cnt, model_cnt);
        chk({tag, "/byte_cnt_l"}, bus_l.byte_cnt, model_cnt);
        chk({tag, "/frame_err_m"}, err_m, err_exp);
        chk({tag, "/frame_err_l"}, err_l, err_exp);
        chk({tag, "/busy_idle"}, {31'd0, bus_m.busy}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "/din"},       bus_m.uprocessor_din,  32'h00);
        chk({tag, "/wren"},      bus_m.uprocessor_wren, 32'd0);
        chk({tag, "/frame_err"}, bus_m.frame_err,       32'd0);
        chk({tag, "/busy"},      bus_m.busy,            32'd0);
        chk({tag, "/byte_cnt"},  bus_m.byte_cnt,        32'd0);
        chk({tag, "/din_l"},     bus_l.uprocessor_din,  32'h00);
    endtask

    initial begin
        // Power-on reset.
        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick(3);

        // Single byte 0xA5; wire order 1,0,1,0,0,1,0,1 also gives 0xA5 LSB-first.
        tx_q.push_back(8'hA5);
        send_frame(0, 1'b1);
        check_frame("a5");
        chk("latency_8th_rise_to_wren", lat, 4);

        // Back-to-back bytes in one frame.
        tx_q.push_back(8'h00);
        tx_q.push_back(8'hFF);
        tx_q.push_back(8'h3C);
        send_frame(0, 1'b0);
        check_frame("multi");

        // Partial byte: frame error, no delivery, din held; then a clean frame.
        send_frame(5, 1'b0);
        check_frame("partial5");
        tx_q.push_back(8'h12);
        send_frame(0, 1'b0);
        check_frame("after_err");

        // Random frames, some ending with a partial byte.
        for (int f = 0; f < 4; f++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom()));
            send_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0, 1'b0);
            check_frame($sformatf("rand%0d", f));
        end

        // Reset halfway through 0xC3.
        cs_n = 1'b0;
        tick(4);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        model_cnt = 0;
        last_m    = 8'h00;
        last_l    = 8'h00;
        cs_n      = 1'b1;
        tick(3);
        rst = 1'b1;
        tick(4);
        tx_q.push_back(8'h81);
        send_frame(0, 1'b0);
        check_frame("post_reset_81");

        // Saturation: reach 255 deliveries, then one more.
        for (int k = 0; k < 254; k++) tx_q.push_back(8'($urandom()));
        send_frame(0, 1'b0);
        check_frame("fill255");
        tx_q.push_back(8'h55);
        send_frame(0, 1'b0);
        check_frame("sat_55");

        chk("wren_err_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: observed no completion, required completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end

endmodule
